// File: rtl/alu_issue_ctrl.sv
// Issue stage for the clock-gated ALU: queues requests, issues one op at a time
// with a single-cycle en pulse, and returns the captured result with its tag.
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [3:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [3:0]                 alu_op,
    output logic                       alu_en,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   count_r;
    logic [LVL_W-1:0]   count_next_s;
    logic               in_ready_r;
    logic [WIDTH-1:0]   mem_a_r   [DEPTH];
    logic [WIDTH-1:0]   mem_b_r   [DEPTH];
    logic [3:0]         mem_op_r  [DEPTH];
    logic [TAG_W-1:0]   mem_tag_r [DEPTH];
    logic               push_s;
    logic               pop_s;
    logic               head_illegal_s;
    logic [WIDTH-1:0]   alu_a_r;
    logic [WIDTH-1:0]   alu_b_r;
    logic [3:0]         alu_op_r;
    logic               alu_en_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_result_r;
    logic [TAG_W-1:0]   out_tag_r;
    logic               out_err_r;

    assign push_s         = in_valid && in_ready_r;
    assign pop_s          = (state_r == IDLE) && (count_r != {LVL_W{1'b0}});
    assign head_illegal_s = (mem_op_r[rd_ptr_r] >= 4'd12);

    // Next occupancy; a simultaneous push and pop leaves the level unchanged
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + LVL_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - LVL_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO pointers, level and registered ready (ready derived from next level)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {LVL_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != LVL_W'(DEPTH));
        end
    end

    // FIFO storage; contents need no reset since the level gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r]   <= in_a;
            mem_b_r[wr_ptr_r]   <= in_b;
            mem_op_r[wr_ptr_r]  <= in_op;
            mem_tag_r[wr_ptr_r] <= in_tag;
        end
    end

    // Issue FSM; ALU operands load only on a legal pop so idle inputs never toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            alu_a_r      <= {WIDTH{1'b0}};
            alu_b_r      <= {WIDTH{1'b0}};
            alu_op_r     <= 4'd0;
            alu_en_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_tag_r    <= {TAG_W{1'b0}};
            out_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        out_tag_r <= mem_tag_r[rd_ptr_r];
                        if (head_illegal_s) begin
                            out_result_r <= {WIDTH{1'b0}};
                            out_err_r    <= 1'b1;
                            out_valid_r  <= 1'b1;
                            state_r      <= RESP;
                        end else begin
                            alu_a_r  <= mem_a_r[rd_ptr_r];
                            alu_b_r  <= mem_b_r[rd_ptr_r];
                            alu_op_r <= mem_op_r[rd_ptr_r];
                            alu_en_r <= 1'b1;
                            state_r  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    alu_en_r <= 1'b0;
                    state_r  <= CAPT;
                end
                CAPT: begin
                    out_result_r <= alu_result;
                    out_err_r    <= 1'b0;
                    out_valid_r  <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    alu_en_r    <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign fifo_level = count_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_op     = alu_op_r;
    assign alu_en     = alu_en_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_tag    = out_tag_r;
    assign out_err    = out_err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural gated-ALU stub plus an in-order
// expected-result queue; directed scenarios followed by a randomized run.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_op;
    logic [3:0]  in_tag;
    logic [2:0]  fifo_level;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_en;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          en_count = 0;
    int          lat;
    bit          prev_en = 1'b0;
    logic [15:0] last_a = 16'h0;
    logic [15:0] last_b = 16'h0;
    logic [3:0]  last_op = 4'h0;

    alu_issue_ctrl #(.WIDTH(16), .DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .fifo_level(fifo_level), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_en(alu_en), .alu_result(alu_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a + 16'd1;
            4'd7:    return a - 16'd1;
            4'd8:    return a << 1;
            4'd9:    return a >> 1;
            4'd10:   return {a[14:0], a[15]};
            4'd11:   return {a[0], a[15:1]};
            default: return 16'h0;
        endcase
    endfunction

    // Gated ALU stub: result register updates only on an enabled edge
    always @(posedge clk) begin
        if (alu_en === 1'b1) alu_result <= alu_fn(alu_a, alu_b, alu_op);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe what the coming posedge will do, update the model, then advance
    task automatic step();
        exp_t e;
        if (rst === 1'b1) begin
            exp_q.delete();
        end else begin
            if (out_valid === 1'b1) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1'b1));
                if (exp_q.size() != 0) begin
                    chk("out_result", 64'(out_result), 64'(exp_q[0].res));
                    chk("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
                    chk("out_err", 64'(out_err), 64'(exp_q[0].err));
                    if (out_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
            if (alu_en === 1'b1) begin
                en_count++;
                chk("en_single_cycle", 64'(prev_en), 64'(1'b0));
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                e.tag = in_tag;
                e.err = (in_op > 4'd11);
                e.res = e.err ? 16'h0 : alu_fn(in_a, in_b, in_op);
                exp_q.push_back(e);
                if (!e.err) begin
                    last_a = in_a; last_b = in_b; last_op = in_op;
                end
            end
        end
        prev_en = (alu_en === 1'b1);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n, input int budget);
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("out_valid_timeout", 64'(out_valid), 64'(1'b1));
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                           input logic [3:0] tag, input logic [15:0] er, input logic ee);
        push(a, b, op, tag);
        wait_out(lat, 20);
        chk("dir_result", 64'(out_result), 64'(er));
        chk("dir_tag", 64'(out_tag), 64'(tag));
        chk("dir_err", 64'(out_err), 64'(ee));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int n_req;
        int n_legal;
        rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_op = 4'h0;
        in_tag = 4'h0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_alu_en", 64'(alu_en), 64'(1'b0));
        chk("rst_level", 64'(fifo_level), 64'(3'd0));
        chk("rst_outs", 64'({alu_a, alu_b, alu_op, out_result, out_tag, out_err}), 64'(0));

        // Basic ADD with latency and a single en pulse
        en_count = 0;
        push(16'h0003, 16'h0004, 4'b0000, 4'd5);
        wait_out(lat, 20);
        chk("t1_latency", 64'(lat), 64'(3));
        chk("t1_result", 64'(out_result), 64'(16'h0007));
        chk("t1_tag", 64'(out_tag), 64'(4'd5));
        chk("t1_err", 64'(out_err), 64'(1'b0));
        chk("t1_en_pulses", 64'(en_count), 64'(1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Hold one result in RESP, then fill the FIFO and try an overflow push
        en_count = 0;
        push(16'($urandom), 16'($urandom), 4'($urandom_range(0, 11)), 4'd1);
        wait_out(lat, 20);
        for (int i = 0; i < 4; i++) begin
            push(16'($urandom), 16'($urandom), 4'($urandom_range(0, 11)), 4'(i + 2));
            chk("t2_level", 64'(fifo_level), 64'(i + 1));
        end
        chk("t2_full_ready", 64'(in_ready), 64'(1'b0));
        push(16'h1234, 16'h5678, 4'd0, 4'd9);
        chk("t2_refused_level", 64'(fifo_level), 64'(3'd4));
        chk("t2_held_valid", 64'(out_valid), 64'(1'b1));
        out_ready = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) step();
        chk("t2_drained", 64'(exp_q.size()), 64'(0));
        chk("t2_en_pulses", 64'(en_count), 64'(5));
        out_ready = 1'b0;
        step();

        // Illegal opcode: zero result, error flag, ALU untouched
        en_count = 0;
        push(16'hBEEF, 16'hCAFE, 4'b1101, 4'd7);
        wait_out(lat, 20);
        chk("t3_latency", 64'(lat), 64'(1));
        chk("t3_result", 64'(out_result), 64'(16'h0));
        chk("t3_err", 64'(out_err), 64'(1'b1));
        chk("t3_tag", 64'(out_tag), 64'(4'd7));
        chk("t3_alu_hold", 64'({alu_a, alu_b, alu_op}), 64'({last_a, last_b, last_op}));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_no_en", 64'(en_count), 64'(0));

        // Rotate wrap and decrement wrap
        run_one(16'h8001, 16'h00FF, 4'b1010, 4'd3, 16'h0003, 1'b0);
        run_one(16'h0000, 16'h0001, 4'b0111, 4'd4, 16'hFFFF, 1'b0);

        // Reset while in CAPT with two entries queued
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            push(16'($urandom), 16'($urandom), 4'($urandom_range(0, 11)), 4'(i + 10));
        chk("t5_level_before", 64'(fifo_level), 64'(3'd2));
        chk("t5_capt_en", 64'(alu_en), 64'(1'b0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_out_valid", 64'(out_valid), 64'(1'b0));
        chk("t5_alu_en", 64'(alu_en), 64'(1'b0));
        chk("t5_level", 64'(fifo_level), 64'(3'd0));
        chk("t5_in_ready", 64'(in_ready), 64'(1'b1));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_no_stale", 64'({out_valid, alu_en}), 64'(2'b00));
        end

        // Idle: ALU interface quiet for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t6_idle", 64'({alu_en, alu_op, alu_a, alu_b}), 64'(0));
        end

        // Randomized traffic against the expected-result queue
        en_count = 0; n_req = 0; n_legal = 0;
        for (int c = 0; c < 3000 && (n_req < 40 || exp_q.size() != 0); c++) begin
            in_valid  = (n_req < 40) && ($urandom_range(0, 1) == 1);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_op     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                    : 4'($urandom_range(0, 11));
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready === 1'b1) begin
                n_req++;
                if (in_op < 4'd12) n_legal++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("rand_all_sent", 64'(n_req), 64'(40));
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        chk("rand_en_pulses", 64'(en_count), 64'(n_legal));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
